// File: rtl/ext_bus_sram_model.sv
// SRAM target hanging off the AS2650 multiplexed external bus.
// Demultiplexes the 15-bit address from le_lo/le_hi, serves CPU reads
// (1-cycle latency) and commits CPU writes on the rising edge of WEb.
// A host valid/ready port shares the single memory port at lowest priority.
module ext_bus_sram_model #(
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [7:0]        bus_out_i,
    input  logic              bus_dir_i,
    input  logic              le_lo_i,
    input  logic              le_hi_i,
    input  logic              oeb_i,
    input  logic              web_i,
    output logic [7:0]        bus_in_o,
    input  logic              host_valid_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic              host_ready_o,
    output logic [7:0]        host_rdata_o,
    output logic              host_rvalid_o,
    output logic              error_o,
    output logic [15:0]       wr_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];

    logic [14:0]       addr_q, addr_d;
    logic              web_q, web_d;
    logic              wr_pend_q, wr_pend_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        bus_in_q, bus_in_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              error_q, error_d;
    logic [15:0]       wr_count_q, wr_count_d;

    logic              in_range;
    logic              commit;
    logic              cpu_rd;
    logic              host_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    // Access arbitration: a CPU commit owns the port, then CPU read, then host.
    always_comb begin
        in_range     = (addr_q[14:ADDR_W] == '0);
        // Commit only fires when data was actually captured while WEb was low.
        commit       = ~web_q & web_i & wr_pend_q;
        cpu_rd       = ~oeb_i & web_i & ~commit;
        host_ready_o = host_valid_i & oeb_i & ~commit;
        host_fire    = host_valid_i & host_ready_o;
        mem_we       = (commit & in_range) | (host_fire & host_we_i);
        mem_waddr    = commit ? addr_q[ADDR_W-1:0] : host_addr_i;
        mem_wdata    = commit ? wdata_q : host_wdata_i;
    end

    // Next-state for address latches, write capture, read data and status.
    always_comb begin
        addr_d        = addr_q;
        web_d         = web_i;
        wr_pend_d     = wr_pend_q;
        wdata_d       = wdata_q;
        bus_in_d      = bus_in_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        error_d       = error_q | (~oeb_i & ~web_i);
        wr_count_d    = wr_count_q + {15'd0, commit};

        if (le_lo_i) addr_d[7:0]  = bus_out_i;
        if (le_hi_i) addr_d[14:8] = bus_out_i[6:0];

        if (~web_i && bus_dir_i) begin
            wdata_d   = bus_out_i;
            wr_pend_d = 1'b1;
        end else if (commit) begin
            wr_pend_d = 1'b0;
        end

        if (cpu_rd)
            bus_in_d = in_range ? mem[addr_q[ADDR_W-1:0]] : OOR_DATA;

        if (host_fire && !host_we_i) begin
            host_rdata_d  = mem[host_addr_i];
            host_rvalid_d = 1'b1;
        end
    end

    // State registers; memory contents are deliberately not reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_q        <= '0;
            web_q         <= 1'b1;
            wr_pend_q     <= 1'b0;
            wdata_q       <= '0;
            bus_in_q      <= OOR_DATA;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            error_q       <= 1'b0;
            wr_count_q    <= '0;
        end else begin
            addr_q        <= addr_d;
            web_q         <= web_d;
            wr_pend_q     <= wr_pend_d;
            wdata_q       <= wdata_d;
            bus_in_q      <= bus_in_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            error_q       <= error_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Single write port into the byte array.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus_in_o      = bus_in_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;
    assign error_o       = error_q;
    assign wr_count_o    = wr_count_q;

endmodule

// File: doc/ext_bus_sram_model.md
Name: ext_bus_sram_model

Overview:
On-die SRAM target that sits directly downstream of the AS2650 external bus pins. It consumes the multiplexed address/data bus (bus_out, le_lo, le_hi, OEb, WEb, bus_dir) and returns read data on the bus_in path. It demultiplexes the 15-bit address and serves CPU reads and writes from a local memory array. A host port with a valid/ready handshake lets the management core preload and inspect memory.

Parameters:
ADDR_W, 10, implemented address bits; array depth is 2**ADDR_W bytes.
OOR_DATA, 8'hFF, value returned for reads outside the implemented range.

Ports:
wb_clk_i  input  1  clock; the same clock as the CPU.
wb_rst_i  input  1  reset, asynchronous, active-high.
bus_out_i  input  8  CPU multiplexed address/data out.
bus_dir_i  input  1  CPU bus direction; 1 = CPU driving.
le_lo_i  input  1  address low-byte latch enable.
le_hi_i  input  1  address high-byte latch enable (bits 14:8, bit 7 ignored).
oeb_i  input  1  CPU read strobe, active-low.
web_i  input  1  CPU write strobe, active-low.
bus_in_o  output  8  read data to CPU bus_in.
host_valid_i  input  1  host request.
host_we_i  input  1  host write; 0 = read.
host_addr_i  input  ADDR_W  host address.
host_wdata_i  input  8  host write data.
host_ready_o  output  1  host request accepted this cycle.
host_rdata_o  output  8  host read data.
host_rvalid_o  output  1  host_rdata_o valid, one-cycle pulse.
error_o  output  1  sticky strobe-conflict flag.
wr_count_o  output  16  CPU write commit counter; wraps.

Behaviour:
- Reset values (asynchronous reset):
  - bus_in_o = OOR_DATA; host_rdata_o = 0; host_rvalid_o = 0; error_o = 0; wr_count_o = 0.
  - Address latches = 0; write-pending flag = 0; web_q = 1.
  - Memory contents are not reset.
- Address latch:
  - Any clock edge with le_lo_i=1 loads addr[7:0] <= bus_out_i.
  - Any clock edge with le_hi_i=1 loads addr[14:8] <= bus_out_i[6:0].
  - If both are high on the same edge, both bytes load from the same bus_out_i value.
  - The latches hold otherwise.
- Range check: in_range = (addr[14:ADDR_W] == 0). Only addr[ADDR_W-1:0] indexes the array.
- CPU read:
  - Each edge with oeb_i=0 and web_i=1 registers bus_in_o <= in_range ? mem[addr] : OOR_DATA. Latency is 1 cycle.
  - With oeb_i=1, bus_in_o holds its last value.
- CPU write:
  - Each edge with web_i=0 captures wdata_q <= bus_out_i and sets the write-pending flag. The last value wins.
  - The write commits on the first edge where web_q=0 and web_i=1, i.e. the rising edge of WEb: mem[addr] <= wdata_q if in_range; wr_count_o increments even when out of range; the pending flag clears.
  - The address used is the latch value at commit time.
- Strobe conflict: oeb_i=0 and web_i=0 on the same edge sets error_o. Only reset clears it. The cycle is treated as a write, and bus_in_o holds.
- Single memory port, one access per cycle. Priority: CPU commit > CPU read > host.
- host_ready_o = host_valid_i & oeb_i & ~commit_this_cycle (combinational).
- Host transfer occurs on an edge with host_valid_i & host_ready_o:
  - Write: mem[host_addr_i] <= host_wdata_i.
  - Read: next cycle host_rdata_o = mem[host_addr_i] and host_rvalid_o = 1 for exactly one cycle.
- The host must hold its request stable until host_ready_o. Stalls are unbounded while OEb stays low.
- A host write and a CPU commit never occur on the same edge (CPU wins).
- Reset mid-operation: a pending CPU write is discarded (no commit), and any in-flight host read produces no host_rvalid_o.
- bus_dir_i is used only for sampling qualification: write-data capture is ignored when bus_dir_i=0.

Test Plan:
1. Reset asserted then released -> bus_in_o=8'hFF, host_ready_o=1 while host_valid_i=1 and oeb_i=1, error_o=0, wr_count_o=0.
2. Host writes 8'hA5 to 10'h123; CPU pulses le_lo with 8'h23, le_hi with 8'h01, then drops oeb_i -> bus_in_o=8'hA5 one cycle after oeb_i low.
3. CPU latches addr 15'h0042, drives 8'h3C with web_i low for 3 cycles, then raises web_i -> exactly one commit; host read of 10'h042 returns 8'h3C with a single host_rvalid_o pulse; wr_count_o=1.
4. CPU latches le_hi=8'h40 (addr 15'h4000, out of range) and reads -> bus_in_o=8'hFF; a write to the same address leaves the array unchanged and wr_count_o still increments.
5. Host read requested while oeb_i held low for 5 cycles -> host_ready_o=0 for those 5 cycles, then accepts; host_rvalid_o follows 1 cycle later.
6. oeb_i and web_i both low for one cycle -> error_o=1 and stays 1; asserting wb_rst_i asynchronously clears it, and a pending write does not commit.
